// File: rtl/dma_pkg.sv
// Shared definitions for the IO-device-2 DMA channel: FSM states, CPU register
// map, CTRL/status bit positions and default geometry.
package dma_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int BUF_DEPTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0] REG_DST  = 2'd0;
  localparam logic [1:0] REG_CNT  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_DONE_CLR = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // Word count actually moved: the device buffer cannot supply more than depth.
  function automatic logic [31:0] clamp_cnt(input logic [31:0] cnt,
                                            input logic [31:0] depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/dma_req_sync.sv
// Two-flop synchronizer for an asynchronous level request, followed by a
// rising-edge detector producing a single-cycle pulse in the clk domain.
module dma_req_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/dma_io2_channel.sv
// Single DMA channel moving words from IO device 2's buffer into memory,
// one word per RD/CAP/WR beat, under CPU-programmed DST/CNT/CTRL registers.
module dma_io2_channel
  import dma_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              GPIO2,
  output logic              Ack2,
  output logic [8:0]        index,
  output logic              IOWrite2,
  input  logic [31:0]       dev_rdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [7:0]        status,
  output logic              done_irq
);

  localparam int REM_W = $clog2(BUF_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       cnt_q;
  logic [REM_W-1:0]  rem_q;
  logic [7:0]        ptr_q;
  logic [31:0]       wdata_q;
  logic              en_q;
  logic              irq_en_q;
  logic              done_q;
  logic              aborted_q;
  logic              abort_pend_q;

  logic req_rise;
  logic ctrl_wr;
  logic abort_p;
  logic done_clr_p;
  logic start;
  logic last_beat;
  logic abort_now;
  logic in_beat;

  dma_req_sync u_req_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (GPIO2),
    .rise_o  (req_rise)
  );

  assign ctrl_wr    = cfg_we && (cfg_addr == REG_CTRL);
  assign abort_p    = ctrl_wr && cfg_wdata[CTRL_ABORT];
  assign done_clr_p = ctrl_wr && cfg_wdata[CTRL_DONE_CLR];
  assign start      = req_rise && (state_q == S_IDLE) && en_q;
  assign last_beat  = (rem_q == REM_W'(1));
  assign abort_now  = abort_p || abort_pend_q;
  assign in_beat    = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cnt_q == 32'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (abort_p) begin
          state_d = S_IDLE;
        end else if (bus_grant) begin
          state_d = S_RD;
        end
      end
      // Grant is not consulted in RD/CAP: a started beat always completes.
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_WR;
      S_WR: begin
        if (abort_now) begin
          state_d = S_IDLE;
        end else if (!last_beat) begin
          state_d = bus_grant ? S_RD : S_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req  = 1'b0;
    index    = 9'd0;
    mem_we   = 1'b0;
    mem_addr = '0;
    Ack2     = 1'b0;
    case (state_q)
      S_REQ: bus_req = 1'b1;
      S_RD: begin
        bus_req = 1'b1;
        index   = {1'b1, ptr_q};
      end
      S_CAP: bus_req = 1'b1;
      S_WR: begin
        bus_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
      end
      S_DONE:  Ack2 = 1'b1;
      default: ;
    endcase
  end

  assign IOWrite2  = 1'b0;
  assign mem_wdata = wdata_q;
  assign status    = {5'd0, aborted_q, done_q, (state_q != S_IDLE)};
  assign done_irq  = done_q & irq_en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q        <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      addr_q       <= '0;
      ptr_q        <= '0;
      rem_q        <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (cfg_we && (state_q == S_IDLE)) begin
        if (cfg_addr == REG_DST) dst_q <= cfg_wdata[ADDR_W-1:0];
        if (cfg_addr == REG_CNT) cnt_q <= cfg_wdata;
      end
      if (ctrl_wr) begin
        en_q     <= cfg_wdata[CTRL_EN];
        irq_en_q <= cfg_wdata[CTRL_IRQ_EN];
      end

      if (start) begin
        addr_q <= dst_q;
        ptr_q  <= 8'd0;
        rem_q  <= REM_W'(clamp_cnt(cnt_q, 32'(BUF_DEPTH)));
      end
      if (state_q == S_CAP) begin
        wdata_q <= dev_rdata;
      end
      if (state_q == S_WR) begin
        addr_q <= addr_q + ADDR_W'(1);
        ptr_q  <= ptr_q + 8'd1;
        rem_q  <= rem_q - REM_W'(1);
      end

      // An abort seen mid-beat is held until the beat's write has been issued.
      if (in_beat && (state_q != S_WR)) begin
        abort_pend_q <= abort_pend_q | abort_p;
      end else begin
        abort_pend_q <= 1'b0;
      end

      // Setting wins over a same-cycle done_clear.
      if (state_q == S_DONE) begin
        done_q <= 1'b1;
      end else if (done_clr_p) begin
        done_q <= 1'b0;
      end
      if (((state_q == S_REQ) && abort_p) || ((state_q == S_WR) && abort_now)) begin
        aborted_q <= 1'b1;
      end else if (done_clr_p) begin
        aborted_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_io2_channel.sv
// Scoreboard bench for dma_io2_channel: expected memory writes are queued when
// a transfer is launched and compared as the channel issues mem_we beats.
module tb_dma_io2_channel;

  localparam int ADDR_W    = 13;
  localparam int BUF_DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              GPIO2;
  logic              Ack2;
  logic [8:0]        index;
  logic              IOWrite2;
  logic [31:0]       dev_rdata = 32'd0;
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [7:0]        status;
  logic              done_irq;

  dma_io2_channel #(.ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .GPIO2     (GPIO2),
    .Ack2      (Ack2),
    .index     (index),
    .IOWrite2  (IOWrite2),
    .dev_rdata (dev_rdata),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .status    (status),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  int          wr_cyc[$];
  logic [31:0] dev_mem[256];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          ack_cnt = 0;
  int          breq_cnt = 0;
  int          breq_rise_cyc = 0;
  logic        breq_prev = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device buffer: read data appears one cycle after index is presented.
  always @(posedge clk) begin
    dev_rdata <= index[8] ? dev_mem[index[7:0]] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_cnt++;
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
    if (Ack2) ack_cnt++;
    if (bus_req) breq_cnt++;
    if (bus_req && !breq_prev) breq_rise_cyc = cyc;
    breq_prev = bus_req;
  end

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 256; i++) dev_mem[i] = base + 32'(i);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] dst, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = dst + ADDR_W'(i);
      e.data = base + 32'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic gpio_pulse();
    @(posedge clk); #1;
    GPIO2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 GPIO2 = 1'b0;
  endtask

  task automatic run_wait(input int budget, input string tag);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      if (status[0]) seen = 1'b1;
      else if (seen) break;
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n;
    int k;
    n = 0;
    k = 0;
    while (n < target && k < 60) begin
      @(posedge clk); #2;
      if (mem_we) n++;
      k++;
    end
    chk(tag, 64'(n), 64'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_status"},   64'(status),    64'd0);
    chk({tag, "_ack"},      64'(Ack2),      64'd0);
    chk({tag, "_busreq"},   64'(bus_req),   64'd0);
    chk({tag, "_we"},       64'(mem_we),    64'd0);
    chk({tag, "_index"},    64'(index),     64'd0);
    chk({tag, "_addr"},     64'(mem_addr),  64'd0);
    chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
    chk({tag, "_irq"},      64'(done_irq),  64'd0);
    chk({tag, "_iowrite"},  64'(IOWrite2),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int a0;
    int b0;
    int hold;
    int we_hold;

    reset = 1'b1; GPIO2 = 1'b0; bus_grant = 1'b1;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    fill(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 reset = 1'b0;

    // Basic 4-word transfer with continuous grant.
    fill(32'hA0);
    cfg_wr(2'd0, 32'h100);
    cfg_wr(2'd1, 32'd4);
    cfg_wr(2'd2, 32'h5);
    w0 = wr_cnt; a0 = ack_cnt;
    push_exp(13'h100, 4, 32'hA0);
    gpio_pulse();
    run_wait(60, "t1");
    chk("t1_writes", 64'(wr_cnt - w0), 64'd4);
    chk("t1_ack", 64'(ack_cnt - a0), 64'd1);
    chk("t1_latency", 64'(wr_cyc[w0] - breq_rise_cyc), 64'd3);
    for (int i = 1; i < 4; i++) chk("t1_gap", 64'(wr_cyc[w0 + i] - wr_cyc[w0 + i - 1]), 64'd3);
    chk("t1_status", 64'(status), 64'h02);
    chk("t1_irq", 64'(done_irq), 64'd1);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    cfg_wr(2'd2, 32'hD);
    @(negedge clk);
    chk("t1_clr_status", 64'(status), 64'h00);
    chk("t1_clr_irq", 64'(done_irq), 64'd0);

    // Zero count: straight to DONE, no bus traffic.
    cfg_wr(2'd1, 32'd0);
    w0 = wr_cnt; a0 = ack_cnt; b0 = breq_cnt;
    gpio_pulse();
    run_wait(20, "t2");
    chk("t2_busreq", 64'(breq_cnt - b0), 64'd0);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd0);
    chk("t2_ack", 64'(ack_cnt - a0), 64'd1);
    chk("t2_status", 64'(status), 64'h02);
    cfg_wr(2'd2, 32'h9);

    // Destination wraps at the top of memory.
    fill(32'h300);
    cfg_wr(2'd0, 32'h1FFE);
    cfg_wr(2'd1, 32'd3);
    w0 = wr_cnt; a0 = ack_cnt;
    push_exp(13'h1FFE, 3, 32'h300);
    gpio_pulse();
    run_wait(60, "t3");
    chk("t3_writes", 64'(wr_cnt - w0), 64'd3);
    chk("t3_ack", 64'(ack_cnt - a0), 64'd1);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    cfg_wr(2'd2, 32'h9);

    // Count above buffer depth is clamped.
    fill(32'hC00);
    cfg_wr(2'd0, 32'h200);
    cfg_wr(2'd1, 32'd40);
    w0 = wr_cnt;
    push_exp(13'h200, BUF_DEPTH, 32'hC00);
    gpio_pulse();
    run_wait(200, "t4");
    chk("t4_writes", 64'(wr_cnt - w0), 64'(BUF_DEPTH));
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    cfg_wr(2'd2, 32'h9);

    // Grant dropped for 4 cycles after word 2.
    fill(32'h500);
    cfg_wr(2'd0, 32'h20);
    cfg_wr(2'd1, 32'd5);
    w0 = wr_cnt; a0 = ack_cnt;
    push_exp(13'h20, 5, 32'h500);
    gpio_pulse();
    wait_writes(2, "t5_w2_seen");
    bus_grant = 1'b0;
    hold = 0; we_hold = 0;
    repeat (4) begin
      @(posedge clk); #2;
      hold += int'(bus_req);
      we_hold += int'(mem_we);
    end
    chk("t5_busreq_held", 64'(hold), 64'd4);
    chk("t5_no_we_dropped", 64'(we_hold), 64'd0);
    bus_grant = 1'b1;
    run_wait(80, "t5");
    chk("t5_writes", 64'(wr_cnt - w0), 64'd5);
    chk("t5_ack", 64'(ack_cnt - a0), 64'd1);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    cfg_wr(2'd2, 32'h9);

    // Abort during word 3 of 8.
    fill(32'h800);
    cfg_wr(2'd0, 32'h40);
    cfg_wr(2'd1, 32'd8);
    w0 = wr_cnt; a0 = ack_cnt;
    push_exp(13'h40, 3, 32'h800);
    gpio_pulse();
    wait_writes(2, "t6_w2_seen");
    cfg_wr(2'd2, 32'h3);
    run_wait(60, "t6");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_writes", 64'(wr_cnt - w0), 64'd3);
    chk("t6_ack", 64'(ack_cnt - a0), 64'd0);
    chk("t6_status", 64'(status), 64'h04);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    cfg_wr(2'd2, 32'h9);
    @(negedge clk);
    chk("t6_clr_status", 64'(status), 64'h00);

    // Reset during word 2 of 6.
    fill(32'h900);
    cfg_wr(2'd0, 32'h80);
    cfg_wr(2'd1, 32'd6);
    w0 = wr_cnt; a0 = ack_cnt;
    push_exp(13'h80, 1, 32'h900);
    gpio_pulse();
    wait_writes(1, "t7_w1_seen");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs("t7");
    reset = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t7_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t7_ack", 64'(ack_cnt - a0), 64'd0);
    chk("t7_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t7_status", 64'(status), 64'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_io2_channel.md
DMA_IO2_CHANNEL -- requirements
Module: dma_io2_channel

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, memory word-address width (8192 words); BUF_DEPTH, default 32, device buffer words.
REQ-002 SHALL have ports, one per line:
  clk  in  1  sole clock, all logic on rising edge
  reset  in  1  synchronous, active-high
  GPIO2  in  1  transfer request from IO device 2, level, asynchronous
  Ack2  out  1  one-cycle transfer-complete acknowledge to IO device 2
  index  out  9  device select/address: [8] chip select, [7:0] buffer word address
  IOWrite2  out  1  device direction; channel always drives 0 (read)
  dev_rdata  in  32  device read data, valid one cycle after index presented
  bus_req  out  1  memory bus request
  bus_grant  in  1  memory bus grant
  mem_addr  out  ADDR_W  memory word address
  mem_wdata  out  32  memory write data
  mem_we  out  1  memory write strobe, one cycle per word
  cfg_we  in  1  CPU register write strobe
  cfg_addr  in  2  register select: 0 DST, 1 CNT, 2 CTRL
  cfg_wdata  in  32  CPU write data
  status  out  8  [0] busy, [1] done, [2] aborted, [7:3] 0
  done_irq  out  1  level interrupt, equals status[1] AND CTRL.irq_en
REQ-003 Clock and reset SHALL be named clk and reset; reset is synchronous, active-high, single clock domain.

Function
REQ-004 GPIO2 SHALL pass through a 2-flop synchronizer; a request is its synchronized rising edge, taken only in IDLE with CTRL.en=1; edges elsewhere are dropped.
REQ-005 States SHALL be IDLE, REQ, RD, CAP, WR, DONE.
REQ-006 IDLE->REQ on request with CNT>0; IDLE->DONE on request with CNT=0 (no bus activity).
REQ-007 REQ: bus_req=1; advance to RD the first cycle bus_grant=1.
REQ-008 RD: index={1'b1, ptr[7:0]}, bus_req=1; next state CAP.
REQ-009 CAP: register dev_rdata into mem_wdata; next state WR.
REQ-010 WR: mem_we=1, mem_addr=dst; then ptr+1, dst+1 (modulo 2^ADDR_W, 8191 wraps to 0), remaining-1; next RD if remaining>0 and grant held, REQ if remaining>0 and grant dropped, else DONE.
REQ-011 Grant loss during RD or CAP SHALL NOT abort the beat; the current word completes, then the channel returns to REQ.
REQ-012 Throughput: 3 cycles per word under continuous grant; first mem_we exactly 3 cycles after grant sampled high.
REQ-013 DONE lasts one cycle: Ack2=1, status.done set, bus_req=0; next IDLE.
REQ-014 CNT values above BUF_DEPTH SHALL be clamped to BUF_DEPTH when the transfer starts; ptr SHALL start at 0.
REQ-015 CPU writes to DST/CNT while busy SHALL be ignored; CTRL writes are always accepted.
REQ-016 CTRL bits: [0] en, [1] abort (self-clearing pulse), [2] irq_en, [3] done_clear (self-clearing, clears status.done and status.aborted).
REQ-017 Abort in REQ SHALL go to IDLE immediately; in RD/CAP/WR it finishes the current word, then goes to IDLE; status.aborted set, no Ack2, status.done unchanged.
REQ-018 Simultaneous done_clear and DONE in the same cycle: done SHALL end set.
REQ-019 index SHALL be 0 and mem_we 0 in all states other than RD and WR respectively.

Reset
REQ-020 On reset: state IDLE; Ack2, bus_req, mem_we, done_irq, IOWrite2 = 0; index, mem_addr, mem_wdata = 0; DST, CNT, CTRL, status, ptr = 0; synchronizer flops = 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no further mem_we and no Ack2.

Structure
REQ-022 Shared package dma_pkg SHALL hold the state enum, register offsets (DST/CNT/CTRL), CTRL and status bit positions, and ADDR_W/BUF_DEPTH defaults.
REQ-023 One sub-module, dma_req_sync (2-flop synchronizer plus rising-edge detect), SHALL be instantiated for GPIO2.

Verification
REQ-024 DST=0x100, CNT=4, en=1, buffer 0xA0..0xA3, grant tied 1, GPIO2 rise -> mem writes 0x100..0x103 = A0..A3, 3 cycles apart, Ack2 one pulse, status=0x02.
REQ-025 CNT=0, GPIO2 rise -> no bus_req, no mem_we, Ack2 pulse, done set.
REQ-026 DST=0x1FFE, CNT=3 -> writes at 0x1FFE, 0x1FFF, 0x0000.
REQ-027 CNT=5, grant dropped for 4 cycles after word 2 -> word 2 completes, bus_req held in REQ, words 3..5 resume, 5 writes total, correct data order.
REQ-028 Abort written during word 3 of CNT=8 -> exactly 3 writes, no Ack2, status=0x04; reset during word 2 of another run -> all outputs at reset values next cycle, no further writes.
